dlfloat_dot_sched: RTL and testbench
====================================

Name: dlfloat_dot_sched

Overview:
- Controller that sequences the DLFloat16 MAC datapath (1 sign, 6 exp, 9 mantissa, bias 31) through one dot-product job of programmable length.
- Clears the accumulator and accepts operand pairs over a valid/ready stream.
- Drains the multiply/accumulate pipeline, then presents the captured result on a valid/ready output.
- Sits between the operand-loading logic and the MAC; it owns the MAC's operand inputs and its accumulator clear.

Parameters:
- LEN_W, 8: width of job length, so the maximum is 2^LEN_W-1 pairs.
- MAC_LAT, 2: clock edges from a mac_a/mac_b change to the corresponding mac_acc update (1 for the product register, 1 for the accumulator register).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs; sampled with start.
- abort  in  1  cancel current job.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid&in_ready.
- in_a  in  16  DLFloat16 operand A.
- in_b  in  16  DLFloat16 operand B.
- mac_a  out  16  registered operand A to MAC.
- mac_b  out  16  registered operand B to MAC.
- mac_clr  out  1  accumulator (and product register) clear, active high.
- mac_acc  in  16  MAC accumulator value.
- out_valid  out  1  result valid.
- out_ready  in  1  result accepted when out_valid&out_ready.
- res_data  out  16  captured dot-product result.
- res_special  out  1  sticky flag: some accepted operand equalled 16'hFFFF.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - mac_a, mac_b, res_data = 16'h0000.
  - mac_clr, out_valid, res_special, in_ready, busy = 0.
  - All counters = 0.
- States: IDLE, CLR, LOAD, DRAIN, DONE.
- IDLE:
  - mac_a/mac_b held at 0.
  - start=1 with len!=0: cnt<=len, res_special<=0, go to CLR.
  - start=1 with len==0: res_data<=0, res_special<=0, go to DONE. No MAC activity.
- CLR:
  - mac_clr=1 for exactly MAC_LAT cycles; mac_a/mac_b=0.
  - Then go to LOAD.
- LOAD:
  - in_ready=1 (combinational from state).
  - On handshake: mac_a<=in_a, mac_b<=in_b, cnt<=cnt-1, res_special|=(in_a==FFFF | in_b==FFFF).
  - Cycle without handshake: mac_a<=0, mac_b<=0 (bubble contributes zero).
  - Handshake with cnt==1: go to DRAIN, dcnt<=MAC_LAT.
- DRAIN:
  - mac_a/mac_b<=0; dcnt decrements each cycle.
  - At the edge where dcnt==0: res_data<=mac_acc, go to DONE.
  - The last pair's contribution therefore lands exactly MAC_LAT+1 edges after its handshake.
- DONE:
  - out_valid=1; res_data stable.
  - out_ready=1: go to IDLE, out_valid drops next cycle.
  - start is ignored in DONE.
- start while busy: ignored, no queuing.
- abort (any non-IDLE state): next state IDLE, out_valid<=0, mac_a/mac_b<=0, in_ready drops immediately.
  - A handshake in the same cycle is discarded.
  - The accumulator is not cleared; the next job's CLR handles it.
  - abort has priority over all transitions.
- Reset mid-job: same end state as the reset values above; no output glitch beyond those values.
- cnt and dcnt never wrap: no decrement at 0.

Decomposition:
- Shared package dlfloat_pkg:
  - DLF_W=16, EXP_W=6, MAN_W=9, DLF_BIAS=31.
  - DLF_ZERO=16'h0000, DLF_SPECIAL=16'hFFFF, DLF_ONE=16'h3E00.
  - State enum for this block.
- No sub-module needed; the counters are inline.
- The integration wrapper ORs mac_clr into the MAC's accumulator and product-register resets.

Test Plan:
- len=2, pairs (3E00,4000),(4000,3E00), in_valid held high -> out_valid rises 3 cycles after the 2nd handshake; res_data=4200 (4.0); res_special=0.
- len=1, pair (4100,4000) with in_valid gapped 3 bubble cycles before the pair -> res_data=4300 (6.0); bubbles add nothing.
- start with len=0 -> DONE next cycle; res_data=0000; mac_clr never asserted.
- len=3, abort after the 1st handshake -> IDLE next cycle, out_valid never rises. Then new job len=1 (3E00,3E00) -> res_data=3E00 (stale partial sum cleared).
- Pair (FFFF,4000) in a len=2 job -> res_special=1 and res_data=FFFF. Start pulsed during DONE while out_ready held low for 5 cycles -> ignored, result held stable.
- rst_n low for 1 cycle during LOAD -> all outputs at their reset values the next cycle; state=IDLE.

Source files
------------

// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 definitions (1 sign, 6 exponent, 9 mantissa, bias 31)
// and the dot-product scheduler state encoding.
package dlfloat_pkg;

   localparam int unsigned DLF_W    = 16;
   localparam int unsigned EXP_W    = 6;
   localparam int unsigned MAN_W    = 9;
   localparam int unsigned DLF_BIAS = 31;

   localparam logic [DLF_W-1:0] DLF_ZERO    = 16'h0000;
   localparam logic [DLF_W-1:0] DLF_SPECIAL = 16'hFFFF;
   localparam logic [DLF_W-1:0] DLF_ONE     = 16'h3E00;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLR   = 3'd1;
   localparam logic [2:0] ST_LOAD  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   function automatic logic is_special(input logic [DLF_W-1:0] v);
      return v == DLF_SPECIAL;
   endfunction

endpackage

// File: rtl/dlfloat_dot_sched.sv
// Sequences the DLFloat16 MAC through one dot-product job: clear, stream
// operand pairs, drain the MAC pipeline, then hold the captured result.
module dlfloat_dot_sched
   import dlfloat_pkg::*;
#(
   parameter int unsigned LEN_W   = 8,
   parameter int unsigned MAC_LAT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_a,
   input  logic [15:0]      in_b,
   output logic [15:0]      mac_a,
   output logic [15:0]      mac_b,
   output logic             mac_clr,
   input  logic [15:0]      mac_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      res_data,
   output logic             res_special,
   output logic             busy
);

   localparam int unsigned DCNT_W = $clog2(MAC_LAT + 1);

   logic [2:0]        state;
   logic [LEN_W-1:0]  cnt;
   logic [DCNT_W-1:0] dcnt;
   logic              hs;

   // in_ready falls with abort in the same cycle so no pair is consumed.
   assign in_ready  = (state == ST_LOAD) && !abort;
   assign hs        = in_valid && in_ready;
   assign mac_clr   = (state == ST_CLR);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         dcnt        <= '0;
         mac_a       <= DLF_ZERO;
         mac_b       <= DLF_ZERO;
         res_data    <= DLF_ZERO;
         res_special <= 1'b0;
      end else if (abort && (state != ST_IDLE)) begin
         state <= ST_IDLE;
         mac_a <= DLF_ZERO;
         mac_b <= DLF_ZERO;
      end else begin
         case (state)
            ST_IDLE: begin
               mac_a <= DLF_ZERO;
               mac_b <= DLF_ZERO;
               if (start) begin
                  res_special <= 1'b0;
                  if (len != '0) begin
                     cnt   <= len;
                     dcnt  <= DCNT_W'(MAC_LAT - 1);
                     state <= ST_CLR;
                  end else begin
                     res_data <= DLF_ZERO;
                     state    <= ST_DONE;
                  end
               end
            end
            ST_CLR: begin
               mac_a <= DLF_ZERO;
               mac_b <= DLF_ZERO;
               if (dcnt == '0) state <= ST_LOAD;
               else            dcnt  <= dcnt - DCNT_W'(1);
            end
            ST_LOAD: begin
               if (hs) begin
                  mac_a       <= in_a;
                  mac_b       <= in_b;
                  res_special <= res_special | is_special(in_a) | is_special(in_b);
                  if (cnt != '0) cnt <= cnt - LEN_W'(1);
                  if (cnt == LEN_W'(1)) begin
                     dcnt  <= DCNT_W'(MAC_LAT);
                     state <= ST_DRAIN;
                  end
               end else begin
                  mac_a <= DLF_ZERO;
                  mac_b <= DLF_ZERO;
               end
            end
            ST_DRAIN: begin
               mac_a <= DLF_ZERO;
               mac_b <= DLF_ZERO;
               // dcnt reaching zero means the last product has landed in mac_acc.
               if (dcnt == '0) begin
                  res_data <= mac_acc;
                  state    <= ST_DONE;
               end else begin
                  dcnt <= dcnt - DCNT_W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dlfloat_dot_sched.sv
// Scoreboard bench for dlfloat_dot_sched with a behavioural DLFloat16 MAC
// and a real-arithmetic reference for each job's expected result.
module tb_dlfloat_dot_sched;

   localparam int unsigned LEN_W   = 8;
   localparam int unsigned MAC_LAT = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] len = '0;
   logic             abort = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [15:0]      in_a = '0;
   logic [15:0]      in_b = '0;
   logic [15:0]      mac_a;
   logic [15:0]      mac_b;
   logic             mac_clr;
   logic [15:0]      mac_acc;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [15:0]      res_data;
   logic             res_special;
   logic             busy;

   dlfloat_dot_sched #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_acc(mac_acc),
      .out_valid(out_valid), .out_ready(out_ready), .res_data(res_data),
      .res_special(res_special), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int clr_cnt = 0;
   logic [16:0] exp_q[$];
   logic [15:0] pa[$];
   logic [15:0] pb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic real dlf2r(input logic [15:0] v);
      real m;
      int  e;
      if (v[14:9] == 6'd0) return 0.0;
      m = 1.0 + real'(v[8:0]) / 512.0;
      e = int'(v[14:9]) - 31;
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      return v[15] ? -m : m;
   endfunction

   function automatic logic [15:0] r2dlf(input real r);
      logic s;
      real  a;
      int   e;
      int   man;
      if (r == 0.0) return 16'h0000;
      s = (r < 0.0);
      a = s ? -r : r;
      e = 31;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0)  begin a = a * 2.0; e--; end
      man = $rtoi((a - 1.0) * 512.0);
      return {s, e[5:0], man[8:0]};
   endfunction

   function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
      if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
      return r2dlf(dlf2r(a) * dlf2r(b));
   endfunction

   function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
      if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
      return r2dlf(dlf2r(a) + dlf2r(b));
   endfunction

   // Behavioural MAC: product register then accumulator register.
   logic [15:0] prod;
   logic [15:0] acc;
   always @(posedge clk) begin
      if (!rst_n || mac_clr) begin
         prod <= 16'h0000;
         acc  <= 16'h0000;
      end else begin
         prod <= fmul(mac_a, mac_b);
         acc  <= fadd(acc, prod);
      end
   end
   assign mac_acc = acc;

   // Monitor: every cycle a result is offered it must match the queue head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mac_clr) clr_cnt++;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
               check("res_data", 32'(res_data), 32'(exp_q[0][15:0]));
               check("res_special", 32'(res_special), 32'(exp_q[0][16]));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   function automatic logic [16:0] ref_result(input int n);
      real  sum = 0.0;
      logic sp  = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (pa[i] == 16'hFFFF || pb[i] == 16'hFFFF) sp = 1'b1;
         else sum = sum + dlf2r(pa[i]) * dlf2r(pb[i]);
      end
      return {sp, sp ? 16'hFFFF : r2dlf(sum)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // gap<0 gives random 0..2 bubbles before each pair; abort_at>=0 aborts after that many handshakes.
   task automatic job(input int n, input int gap, input int abort_at, input int hold, input bit poke);
      int clr0;
      int done;
      int k;
      bit hs;
      if (abort_at < 0) exp_q.push_back(ref_result(n));
      clr0  = clr_cnt;
      start = 1'b1;
      len   = LEN_W'(n);
      tick();
      start = 1'b0;
      if (n == 0) check("len0_done_next", 32'(out_valid), 32'd1);
      done = 0;
      while (done < n) begin
         if (done == abort_at) begin
            abort    = 1'b1;
            in_valid = 1'b1;
            in_a     = pa[done];
            in_b     = pb[done];
            #1 check("abort_in_ready", 32'(in_ready), 32'd0);
            tick();
            abort    = 1'b0;
            in_valid = 1'b0;
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_out_valid", 32'(out_valid), 32'd0);
            check("abort_mac_a", 32'(mac_a), 32'd0);
            check("abort_clr_cycles", 32'(clr_cnt - clr0), 32'(MAC_LAT));
            return;
         end
         repeat ((gap < 0) ? $urandom_range(2, 0) : gap) begin
            in_valid = 1'b0;
            tick();
         end
         in_valid = 1'b1;
         in_a     = pa[done];
         in_b     = pb[done];
         k = 0;
         do begin
            @(negedge clk);
            hs = in_ready;
            tick();
            k++;
         end while (!hs && k < 20);
         if (!hs) begin
            check("handshake_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
         end
         done++;
      end
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 20) begin tick(); k++; end
      check("result_latency", 32'(k), (n == 0) ? 32'd0 : 32'(MAC_LAT + 1));
      check("clr_cycles", 32'(clr_cnt - clr0), (n == 0) ? 32'd0 : 32'(MAC_LAT));
      repeat (hold) begin
         if (poke) begin start = 1'b1; len = LEN_W'(1); end
         tick();
         start = 1'b0;
      end
      out_ready = 1'b1;
      k = 0;
      do begin tick(); k++; end while (busy && k < 20);
      out_ready = 1'b0;
      check("back_to_idle", 32'(busy), 32'd0);
      check("out_valid_dropped", 32'(out_valid), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   localparam int NVALS = 9;
   logic [15:0] vals[NVALS] = '{16'h0000, 16'h3E00, 16'h4000, 16'h4100, 16'h3C00,
                                16'h3F00, 16'hBE00, 16'hC000, 16'h4200};

   initial begin
      int n;
      rst_n = 1'b0;
      repeat (2) tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_mac_clr", 32'(mac_clr), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_mac_a", 32'(mac_a), 32'd0);
      check("rst_res_data", 32'(res_data), 32'd0);
      rst_n = 1'b1;
      tick();

      pa = '{16'h3E00, 16'h4000}; pb = '{16'h4000, 16'h3E00};
      job(2, 0, -1, 0, 1'b0);
      pa = '{16'h4100}; pb = '{16'h4000};
      job(1, 3, -1, 0, 1'b0);
      job(0, 0, -1, 1, 1'b0);
      pa = '{16'h3E00, 16'h3E00, 16'h3E00}; pb = '{16'h4200, 16'h4200, 16'h4200};
      job(3, 0, 1, 0, 1'b0);
      tick();
      pa = '{16'h3E00}; pb = '{16'h3E00};
      job(1, 0, -1, 0, 1'b0);
      pa = '{16'hFFFF, 16'h3E00}; pb = '{16'h4000, 16'h4000};
      job(2, 0, -1, 5, 1'b1);

      for (int j = 0; j < 20; j++) begin
         n = $urandom_range(8, 1);
         pa.delete(); pb.delete();
         for (int i = 0; i < n; i++) begin
            pa.push_back(($urandom_range(15, 0) == 0) ? 16'hFFFF : vals[$urandom_range(NVALS - 1, 0)]);
            pb.push_back(vals[$urandom_range(NVALS - 1, 0)]);
         end
         job(n, -1, -1, $urandom_range(3, 0), 1'b0);
      end

      // Reset in the middle of LOAD after one special pair has been accepted.
      start = 1'b1; len = LEN_W'(4);
      tick();
      start = 1'b0;
      in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h3E00;
      for (int k = 0; k < 20 && !in_ready; k++) tick();
      tick();
      in_valid = 1'b0;
      check("pre_rst_special", 32'(res_special), 32'd1);
      rst_n = 1'b0;
      tick();
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_mac_clr", 32'(mac_clr), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_res_special", 32'(res_special), 32'd0);
      check("midrst_mac_a", 32'(mac_a), 32'd0);
      check("midrst_mac_b", 32'(mac_b), 32'd0);
      check("midrst_res_data", 32'(res_data), 32'd0);
      rst_n = 1'b1;
      repeat (3) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
